// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable data width, optional parity
// and one or two stop bits. It feeds the AES key/plaintext byte loader.
//
// state  | meaning
// IDLE   | waiting for a high-to-low edge on the synchronised line
// START  | half a bit period in, confirm the start bit is still low
// DATA   | sample DATA_BITS bits, LSB first, one per bit period
// PARITY | sample the parity bit (only when PARITY_MODE != 0)
// STOP   | sample STOP_BITS stop bits, latch a framing error on any low
// DONE   | one cycle: offer the frame to the output register
//
// Ports:
//   uart_clock       system clock, all logic on the rising edge
//   uart_reset       asynchronous active-high reset
//   uart_d_in        serial line, idle high, asynchronous to uart_clock
//   uart_ready       consumer accepts the held word
//   uart_d_out       received word, first bit on the line at bit 0
//   uart_valid       uart_d_out and the error flags hold an unconsumed frame
//   uart_parity_err  parity mismatch for the held frame
//   uart_frame_err   a stop bit of the held frame was sampled low
//   uart_overrun     one-cycle pulse when a completed frame is dropped
//   uart_busy        receiver FSM is not in IDLE
module uart_rx_cfg #(
  parameter logic [27:0] CLOCK_FREQ  = 28'd50000000,
  parameter logic [23:0] BAUD_RATE   = 24'd4000000,
  parameter int          DATA_BITS   = 8,
  parameter int          PARITY_MODE = 0,
  parameter int          STOP_BITS   = 1
) (
  input  logic                 uart_clock,
  input  logic                 uart_reset,
  input  logic                 uart_d_in,
  input  logic                 uart_ready,
  output logic [DATA_BITS-1:0] uart_d_out,
  output logic                 uart_valid,
  output logic                 uart_parity_err,
  output logic                 uart_frame_err,
  output logic                 uart_overrun,
  output logic                 uart_busy
);

  localparam logic [27:0] RATIO = CLOCK_FREQ / {4'd0, BAUD_RATE};
  localparam logic [23:0] PULSE = RATIO[23:0];
  localparam logic [23:0] HALF  = {1'b0, PULSE[23:1]};

  if (RATIO < 28'd4) begin : g_ratio_chk
    $error("uart_rx_cfg: CLOCK_FREQ/BAUD_RATE must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_width_chk
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_parity_chk
    $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t               state, state_next;
  logic                 sync1, rx_s, rx_p;
  logic                 fell;
  logic                 edge_pend;
  logic [23:0]          cnt;
  logic [23:0]          cnt_tgt;
  logic                 tick;
  logic [3:0]           bit_cnt;
  logic                 last_data, last_stop;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err_q, frame_err_q;

  assign fell      = rx_p & ~rx_s;
  assign uart_busy = (state != IDLE);

  always_ff @(posedge uart_clock or posedge uart_reset) begin
    if (uart_reset) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_tgt    = (state == START) ? (HALF - 24'd1) : (PULSE - 24'd1);
    tick       = (cnt == cnt_tgt);
    last_data  = (bit_cnt == 4'(DATA_BITS - 1));
    last_stop  = (bit_cnt == 4'(STOP_BITS - 1));
    case (state)
      IDLE:    if (fell || edge_pend) state_next = START;
      START:   if (tick) state_next = rx_s ? IDLE : DATA;
      DATA:    if (tick && last_data) state_next = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick && last_stop) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge uart_clock or posedge uart_reset) begin
    if (uart_reset) begin
      sync1           <= 1'b1;
      rx_s            <= 1'b1;
      rx_p            <= 1'b1;
      edge_pend       <= 1'b0;
      cnt             <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      par_err_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      uart_d_out      <= '0;
      uart_valid      <= 1'b0;
      uart_parity_err <= 1'b0;
      uart_frame_err  <= 1'b0;
      uart_overrun    <= 1'b0;
    end else begin
      sync1        <= uart_d_in;
      rx_s         <= sync1;
      rx_p         <= rx_s;
      uart_overrun <= 1'b0;
      // An edge seen during DONE would be gone by the IDLE cycle; hold it over.
      edge_pend    <= (state == DONE) && fell;

      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 24'd1;

      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (tick && (state == DATA || state == STOP)) begin
        bit_cnt <= (state_next != state) ? 4'd0 : bit_cnt + 4'd1;
      end

      if (state == DATA && tick) begin
        shift <= {rx_s, shift[DATA_BITS-1:1]};
      end

      if (state == START) begin
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      if (state == PARITY && tick) begin
        par_err_q <= (PARITY_MODE == 1) ? (^shift ^ rx_s) : ~(^shift ^ rx_s);
      end
      if (state == STOP && tick && !rx_s) begin
        frame_err_q <= 1'b1;
      end

      if (state == DONE) begin
        if (!uart_valid || uart_ready) begin
          uart_d_out      <= shift;
          uart_parity_err <= par_err_q;
          uart_frame_err  <= frame_err_q;
          uart_valid      <= 1'b1;
        end else begin
          uart_overrun <= 1'b1;
        end
      end else if (uart_valid && uart_ready) begin
        uart_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, next generation of the fixed 8N1 receiver in the encryption datapath front end. It supports configurable data width, optional parity and 1 or 2 stop bits. It adds an input synchroniser, false-start rejection, parity and framing error flags, and a valid/ready output register with overrun detection. It sits between the board RX pin and the AES key/plaintext byte loader.

## Interface
- CLOCK_FREQ, 28'd50000000: system clock frequency in Hz.
- BAUD_RATE, 24'd4000000: line rate in bit/s. CLOCK_FREQ/BAUD_RATE must be ≥ 4, checked at elaboration.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- uart_clock  input  1  system clock; all logic on its rising edge.
- uart_reset  input  1  asynchronous, active-high reset.
- uart_d_in  input  1  serial line, idle high, asynchronous to uart_clock.
- uart_ready  input  1  consumer accepts the held word.
- uart_d_out  output  DATA_BITS  received word, LSB first on the line, LSB at bit 0.
- uart_valid  output  1  uart_d_out and the error flags hold an unconsumed frame.
- uart_parity_err  output  1  parity mismatch for the held frame; always 0 when PARITY_MODE = 0.
- uart_frame_err  output  1  at least one stop bit of the held frame sampled low.
- uart_overrun  output  1  one-cycle pulse: a completed frame was dropped.
- uart_busy  output  1  FSM not in IDLE.

## Operation
- Derived constants: PULSE = CLOCK_FREQ/BAUD_RATE (integer truncation); HALF = PULSE/2. The baud counter is 24 bits wide.
- Synchroniser: two flops on uart_d_in, both reset to 1. Let rx_s be the second-flop output and rx_p its one-cycle delay (reset 1).
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: on rx_p = 1 and rx_s = 0 (falling edge), clear the counter and go to START. A constant-low line never triggers a start.
- START: count to HALF−1, then sample rx_s.
  - rx_s = 1: false start; return to IDLE with no flags and no valid.
  - rx_s = 0: clear the counter and go to DATA.
- DATA: sample rx_s each time the counter reaches PULSE−1, then reset the counter. Shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY_MODE ≠ 0, else go to STOP.
- PARITY: sample after PULSE cycles.
  - Even mode: error if the XOR of data and the parity bit is 1.
  - Odd mode: error if that XOR is 0.
- STOP: sample STOP_BITS bits at PULSE spacing. Any low sample sets the frame-error latch. Then go to DONE.
- DONE: one cycle, then IDLE. The frame is offered to the output register in this cycle.
- Output register, evaluated in the DONE cycle:
  - uart_valid = 0, or uart_valid = 1 with uart_ready = 1: load data and both flags; uart_valid = 1.
  - uart_valid = 1 with uart_ready = 0: drop the new frame, keep the held contents, and pulse uart_overrun for one cycle.
- Outside DONE, uart_valid clears on the cycle after uart_ready = 1 is sampled while uart_valid = 1. uart_d_out and the flags keep their last values.
- A frame with a framing error is still delivered, with uart_frame_err = 1. The next start requires a fresh high-to-low edge, so a break condition produces exactly one frame.
- Reset, asserted at any time including mid-frame:
  - All outputs go to 0 (uart_d_out = 0, uart_valid = 0, both error flags = 0, uart_overrun = 0, uart_busy = 0).
  - The FSM goes to IDLE, the counters and shift register clear, and the synchroniser flops go to 1.
  - After release, a partially received frame is ignored until the next falling edge.

## Timing
- Let E be the cycle in which IDLE sees the falling edge on rx_s; this is 2–3 cycles after the pin edge.
- Start-bit sample: E+HALF.
- Data bit k (k = 0..DATA_BITS−1) sample: E+HALF+(k+1)·PULSE.
- Parity sample: E+HALF+(DATA_BITS+1)·PULSE.
- Stop samples follow at PULSE spacing.
- DONE is the cycle after the last stop sample; uart_valid is high the cycle after DONE.
- uart_busy is high from E+1 through DONE.
- Back-to-back frames: a falling edge arriving while the FSM is in DONE is caught in IDLE on the next cycle. Any frame with at least one full stop bit is received.

## Test plan
- PULSE = 10 (50 MHz, 5 Mbit/s), 8N1, uart_ready = 1: send 0x55 → uart_d_out = 0x55, uart_valid high for exactly 1 cycle, both error flags 0, valid rises E+HALF+9·PULSE+2 cycles after E.
- PARITY_MODE = 1, send 0xA3 with parity bit 1 → uart_d_out = 0xA3, uart_parity_err = 1. Resend with parity bit 0 → uart_parity_err = 0.
- 8N1, send 0x0F with the stop bit driven low → uart_d_out = 0x0F, uart_frame_err = 1. Hold the line low for 50 cycles → no second frame.
- Low glitch of 3 cycles on an idle line → no uart_valid, uart_busy drops within HALF+2 cycles of rising, FSM back in IDLE.
- uart_ready = 0, send 0x12 then 0x34 back-to-back → uart_d_out stays 0x12, uart_valid stays 1, uart_overrun pulses 1 cycle at the second DONE. Then raise uart_ready → uart_valid drops the next cycle.
- Assert uart_reset during data bit 3 of 0xC3, release, then send 0x5A → no output for the aborted frame, uart_d_out = 0x5A, flags 0.
